// File: rtl/square_gen.sv
// Programmable square-wave generator with glitch-free reconfiguration at period boundaries.
// Optional feature macro: SQUARE_GEN_CNT_EN builds the completed-period counter on cycle_cnt.
module square_gen #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [W-1:0] cfg_period,
    input  logic [W-1:0] cfg_high,
    output logic         sigout,
    output logic         edge_pulse,
    output logic [7:0]   cycle_cnt
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] per_q, per_d;
    logic [W-1:0] hi_q, hi_d;
    logic         act_valid_q, act_valid_d;
    logic         pend_q, pend_d;
    logic [W-1:0] pend_per_q, pend_per_d;
    logic [W-1:0] pend_hi_q, pend_hi_d;
    logic         sigout_d;
    logic         edge_pulse_d;

    logic         hs_c;
    logic         apply_c;
    logic [W-1:0] eff_per_c;
    logic [W-1:0] eff_hi_c;
    logic [W-1:0] san_per_c;
    logic [W-1:0] san_hi_c;

    // Sanitise offered config: period at least 2, high time inside 1..per-1.
    always_comb begin
        san_per_c = (cfg_period < W'(2)) ? W'(2) : cfg_period;
        san_hi_c  = cfg_high;
        if (cfg_high == '0) begin
            san_hi_c = W'(1);
        end else if (cfg_high >= san_per_c) begin
            san_hi_c = san_per_c - W'(1);
        end
    end

    // Config that will govern the next period if a pending value is applied now.
    always_comb begin
        eff_per_c = pend_q ? pend_per_q : per_q;
        eff_hi_c  = pend_q ? pend_hi_q  : hi_q;
    end

    assign hs_c = cfg_valid && cfg_ready;

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        per_d        = per_q;
        hi_d         = hi_q;
        act_valid_d  = act_valid_q;
        pend_d       = pend_q;
        pend_per_d   = pend_per_q;
        pend_hi_d    = pend_hi_q;
        sigout_d     = 1'b0;
        edge_pulse_d = 1'b0;
        apply_c      = 1'b0;

        case (state_q)
            IDLE: begin
                apply_c = pend_q;
                if (enable && act_valid_q) begin
                    state_d      = HIGH;
                    cnt_d        = eff_hi_c - W'(1);
                    sigout_d     = 1'b1;
                    edge_pulse_d = 1'b1;
                end
            end
            HIGH: begin
                sigout_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d  = LOW;
                    cnt_d    = per_q - hi_q - W'(1);
                    sigout_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - W'(1);
                end
            end
            LOW: begin
                if (cnt_q == '0) begin
                    // Period boundary: either start the next period or park in IDLE.
                    if (enable) begin
                        state_d      = HIGH;
                        apply_c      = pend_q;
                        cnt_d        = eff_hi_c - W'(1);
                        sigout_d     = 1'b1;
                        edge_pulse_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (apply_c) begin
            per_d       = pend_per_q;
            hi_d        = pend_hi_q;
            act_valid_d = 1'b1;
            pend_d      = 1'b0;
        end

        // A new handshake wins over the clear, and loads after the old value was consumed.
        if (hs_c) begin
            pend_d     = 1'b1;
            pend_per_d = san_per_c;
            pend_hi_d  = san_hi_c;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            per_q       <= '0;
            hi_q        <= '0;
            act_valid_q <= 1'b0;
            pend_q      <= 1'b0;
            pend_per_q  <= '0;
            pend_hi_q   <= '0;
            sigout      <= 1'b0;
            edge_pulse  <= 1'b0;
            cfg_ready   <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            per_q       <= per_d;
            hi_q        <= hi_d;
            act_valid_q <= act_valid_d;
            pend_q      <= pend_d;
            pend_per_q  <= pend_per_d;
            pend_hi_q   <= pend_hi_d;
            sigout      <= sigout_d;
            edge_pulse  <= edge_pulse_d;
            cfg_ready   <= !pend_d;
        end
    end

`ifdef SQUARE_GEN_CNT_EN
    logic wrap_c;

    // LOW -> HIGH boundary marks one completed period.
    assign wrap_c = (state_q == LOW) && (cnt_q == '0) && enable;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_cnt <= '0;
        end else if (wrap_c) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
    end
`else
    assign cycle_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_square_gen.sv
// Directed bench for square_gen: period-position reference model checked every cycle plus literal spot checks.
module tb_square_gen;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_period;
    logic [W-1:0] cfg_high;
    logic         sigout;
    logic         edge_pulse;
    logic [7:0]   cycle_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Reference model state: a running flag and the position inside the current period.
    bit m_run, m_valid, m_pend, m_ep;
    int m_pos, m_per, m_hi, m_pper, m_phi, m_cnt;

    square_gen #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .sigout     (sigout),
        .edge_pulse (edge_pulse),
        .cycle_cnt  (cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
        end
    endtask

    task automatic model_step();
        bit hs;
        bit old_valid;
        int sp;
        int sh;
        hs = cfg_valid && !m_pend;
        m_ep = 0;
        if (!rst) begin
            m_run = 0; m_valid = 0; m_pend = 0; m_cnt = 0;
            m_pos = 0; m_per = 0; m_hi = 0; m_pper = 0; m_phi = 0;
        end else begin
            if (m_run) begin
                m_pos++;
                if (m_pos == m_per) begin
                    if (enable) begin
                        if (m_pend) begin
                            m_per = m_pper; m_hi = m_phi; m_pend = 0;
                        end
                        m_pos = 0;
                        m_ep  = 1;
                        m_cnt = (m_cnt + 1) % 256;
                    end else begin
                        m_run = 0;
                    end
                end
            end else begin
                old_valid = m_valid;
                if (m_pend) begin
                    m_per = m_pper; m_hi = m_phi; m_pend = 0; m_valid = 1;
                end
                if (old_valid && enable) begin
                    m_run = 1; m_pos = 0; m_ep = 1;
                end
            end
            if (hs) begin
                sp = int'(cfg_period);
                sh = int'(cfg_high);
                if (sp < 2) sp = 2;
                if (sh < 1) sh = 1;
                if (sh > sp - 1) sh = sp - 1;
                m_pend = 1; m_pper = sp; m_phi = sh;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        chk_en = 1;
    end

    // Per-cycle comparison against the model.
    initial forever begin
        int exp_cnt;
        @(negedge clk);
        if (chk_en) begin
`ifdef SQUARE_GEN_CNT_EN
            exp_cnt = m_cnt;
`else
            exp_cnt = 0;
`endif
            check("sigout", int'(sigout), (m_run && (m_pos < m_hi)) ? 1 : 0);
            check("edge_pulse", int'(edge_pulse), int'(m_ep));
            check("cfg_ready", int'(cfg_ready), int'(!m_pend));
            check("cycle_cnt", int'(cycle_cnt), exp_cnt);
        end
    end

    task automatic offer(input int p, input int h);
        cfg_period = W'(p);
        cfg_high   = W'(h);
        cfg_valid  = 1'b1;
        @(posedge clk); #1;
        cfg_valid  = 1'b0;
    endtask

    task automatic window(input int n, output int highs, output int edges);
        highs = 0;
        edges = 0;
        repeat (n) begin
            @(negedge clk);
            highs += int'(sigout);
            edges += int'(edge_pulse);
        end
    endtask

    task automatic wait_edge(input string nm);
        bit seen;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (edge_pulse) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: no edge_pulse within 100 cycles (got 0 want 1)", nm);
        end
    endtask

    initial begin
        int hs_cnt, ed_cnt;
        bit r, e, acc;
        int exp260;

        rst = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
        cfg_period = '0; cfg_high = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sigout", int'(sigout), 0);
        check("rst_edge", int'(edge_pulse), 0);
        check("rst_ready", int'(cfg_ready), 1);
        check("rst_cnt", int'(cycle_cnt), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Enable without any config: must stay idle.
        enable = 1'b1;
        window(5, hs_cnt, ed_cnt);
        check("noconfig_highs", hs_cnt, 0);

        // 10/5 steady state.
        offer(10, 5);
        wait_edge("start_10_5");
        window(40, hs_cnt, ed_cnt);
        check("p10_highs", hs_cnt, 20);
        check("p10_edges", ed_cnt, 4);

        // Degenerate config clamps to 2/1.
        offer(1, 0);
        repeat (30) @(negedge clk);
        window(20, hs_cnt, ed_cnt);
        check("p2_highs", hs_cnt, 10);
        check("p2_edges", ed_cnt, 10);

        // Mid-HIGH reconfiguration to 20/2, with a second offer held off until the boundary.
        offer(10, 5);
        repeat (25) @(negedge clk);
        wait_edge("resync_10_5");
        @(posedge clk); #1;
        offer(20, 2);
        @(negedge clk);
        check("pend_ready_low", int'(cfg_ready), 0);
        cfg_period = W'(6); cfg_high = W'(3); cfg_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            r = cfg_ready;
            e = edge_pulse;
            @(posedge clk); #1;
            if (r) begin
                cfg_valid = 1'b0;
                acc = 1;
                check("accept_after_boundary", int'(e), 1);
            end
        end
        cfg_valid = 1'b0;
        check("second_offer_accepted", int'(acc), 1);
        window(19, hs_cnt, ed_cnt);
        check("p20_rest_highs", hs_cnt, 1);
        check("p20_rest_edges", ed_cnt, 0);
        @(negedge clk);
        check("p6_start_edge", int'(edge_pulse), 1);
        window(12, hs_cnt, ed_cnt);
        check("p6_highs", hs_cnt, 6);
        check("p6_edges", ed_cnt, 2);

        // Enable drops 3 cycles into a 10/5 period.
        offer(10, 5);
        repeat (10) @(negedge clk);
        wait_edge("start_drop");
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b0;
        window(7, hs_cnt, ed_cnt);
        check("drop_tail_highs", hs_cnt, 2);
        window(20, hs_cnt, ed_cnt);
        check("drop_idle_highs", hs_cnt, 0);
        check("drop_idle_edges", ed_cnt, 0);

        // Enable glitch within one period continues seamlessly.
        enable = 1'b1;
        wait_edge("restart");
        repeat (2) @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b1;
        wait_edge("glitch_next");
        window(20, hs_cnt, ed_cnt);
        check("glitch_highs", hs_cnt, 10);
        check("glitch_edges", ed_cnt, 2);

        // Reset during HIGH truncates immediately.
        wait_edge("pre_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_sigout", int'(sigout), 0);
        check("midrst_cnt", int'(cycle_cnt), 0);
        check("midrst_ready", int'(cfg_ready), 1);
        window(5, hs_cnt, ed_cnt);
        check("midrst_noconfig", hs_cnt, 0);

        // 260 periods of 2 cycles: counter wraps to 4.
        offer(2, 1);
        wait_edge("start_260");
        repeat (520) @(posedge clk);
        @(negedge clk);
`ifdef SQUARE_GEN_CNT_EN
        exp260 = 4;
`else
        exp260 = 0;
`endif
        check("cnt_260", int'(cycle_cnt), exp260);

        enable = 1'b0;
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
